// File: rtl/simple_axi_master_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simple_axi_master_arbiter_pkg
// Description : Shared state encoding and command codes for the host-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package simple_axi_master_arbiter_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_CLEAR = 3'd4
    } state_t;

    localparam logic [1:0] c_rw_read  = 2'b01;
    localparam logic [1:0] c_rw_write = 2'b10;

endpackage
`default_nettype wire

// File: rtl/simple_axi_master_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : simple_axi_master_arbiter_if
// Description : Command/status bundle between the arbiter and simple_axi_master.
// Revision    : 1.0 - initial release
// ============================================================================
interface simple_axi_master_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       m_rw;
    logic [2:0]       m_size;
    logic [31:0]      m_addr;
    logic [WIDTH-1:0] m_wdata;
    logic             m_clear;
    logic [WIDTH-1:0] m_rdata;
    logic             m_wait;
    logic             m_done;
    logic             m_error;
    logic             m_invalid;

    modport master (
        output m_rw, m_size, m_addr, m_wdata, m_clear,
        input  m_rdata, m_wait, m_done, m_error, m_invalid
    );

    modport slave (
        input  m_rw, m_size, m_addr, m_wdata, m_clear,
        output m_rdata, m_wait, m_done, m_error, m_invalid
    );
endinterface
`default_nettype wire

// File: rtl/simple_axi_master_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : simple_axi_master_arbiter_rr_pick
// Description : Combinational round-robin picker: first request at/after ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module simple_axi_master_arbiter_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  wire logic [NREQ-1:0] i_req,
    input  wire logic [IDXW-1:0] i_ptr,
    output logic      [NREQ-1:0] o_onehot,
    output logic      [IDXW-1:0] o_idx,
    output logic                 o_valid
);
    logic [NREQ-1:0] w_rot;
    int              w_sel;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        w_sel    = 0;
        // Bit k of the rotated vector is requester (ptr + k) mod NREQ.
        w_rot    = NREQ'({i_req, i_req} >> i_ptr);
        // Scan from the far end so the nearest request is the final assignment.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sel   = int'(i_ptr) + k;
                if (w_sel >= NREQ) begin
                    w_sel = w_sel - NREQ;
                end
                o_valid = 1'b1;
            end
        end
        if (o_valid) begin
            o_idx    = IDXW'(w_sel);
            o_onehot = NREQ'(1) << w_sel;
        end
    end
endmodule
`default_nettype wire

// File: rtl/simple_axi_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : simple_axi_master_arbiter
// Description : Round-robin sharing of one simple_axi_master port by NREQ requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module simple_axi_master_arbiter
    import simple_axi_master_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
) (
    input  wire logic                  i_clk,
    input  wire logic                  i_rstn,
    input  wire logic [NREQ-1:0]       i_req,
    input  wire logic [2*NREQ-1:0]     i_req_rw,
    input  wire logic [3*NREQ-1:0]     i_req_size,
    input  wire logic [32*NREQ-1:0]    i_req_addr,
    input  wire logic [WIDTH*NREQ-1:0] i_req_wdata,
    output logic      [NREQ-1:0]       o_gnt,
    output logic      [NREQ-1:0]       o_resp_valid,
    output logic      [WIDTH-1:0]      o_resp_rdata,
    output logic                       o_resp_error,
    output logic                       o_resp_invalid,
    output logic                       o_busy,
    simple_axi_master_arbiter_if.master m_bus
);
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t           r_state;
    logic [IDXW-1:0]  r_ptr;
    logic [1:0]       r_rw;
    logic [2:0]       r_size;
    logic [31:0]      r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic [1:0]       r_m_rw;
    logic             r_m_clear;

    logic [NREQ-1:0]  w_pick_onehot;
    logic [IDXW-1:0]  w_pick_idx;
    logic             w_pick_valid;

    logic [1:0]       w_rw_arr    [NREQ];
    logic [2:0]       w_size_arr  [NREQ];
    logic [31:0]      w_addr_arr  [NREQ];
    logic [WIDTH-1:0] w_wdata_arr [NREQ];

    generate
        for (genvar g = 0; g < NREQ; g++) begin : g_unpack
            assign w_rw_arr[g]    = i_req_rw[g*2 +: 2];
            assign w_size_arr[g]  = i_req_size[g*3 +: 3];
            assign w_addr_arr[g]  = i_req_addr[g*32 +: 32];
            assign w_wdata_arr[g] = i_req_wdata[g*WIDTH +: WIDTH];
        end
    endgenerate

    simple_axi_master_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_pick (
        .i_req    (i_req),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    assign m_bus.m_rw    = r_m_rw;
    assign m_bus.m_size  = r_size;
    assign m_bus.m_addr  = r_addr;
    assign m_bus.m_wdata = r_wdata;
    assign m_bus.m_clear = r_m_clear;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state        <= S_IDLE;
            r_ptr          <= '0;
            r_rw           <= '0;
            r_size         <= '0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_m_rw         <= '0;
            r_m_clear      <= 1'b0;
            o_gnt          <= '0;
            o_resp_valid   <= '0;
            o_resp_rdata   <= '0;
            o_resp_error   <= 1'b0;
            o_resp_invalid <= 1'b0;
            o_busy         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A done still high from an earlier command must be cleared first.
                    if (w_pick_valid && !m_bus.m_wait && !m_bus.m_done) begin
                        r_rw    <= w_rw_arr[w_pick_idx];
                        r_size  <= w_size_arr[w_pick_idx];
                        r_addr  <= w_addr_arr[w_pick_idx];
                        r_wdata <= w_wdata_arr[w_pick_idx];
                        r_m_rw  <= w_rw_arr[w_pick_idx];
                        o_gnt   <= w_pick_onehot;
                        o_busy  <= 1'b1;
                        r_ptr   <= (w_pick_idx == IDXW'(NREQ - 1)) ? '0 : w_pick_idx + 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_m_rw  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (m_bus.m_done) begin
                        o_resp_rdata   <= m_bus.m_rdata;
                        o_resp_error   <= m_bus.m_error;
                        o_resp_invalid <= m_bus.m_invalid;
                        o_resp_valid   <= o_gnt;
                        r_state        <= S_RESP;
                    end
                end
                S_RESP: begin
                    o_resp_valid <= '0;
                    o_gnt        <= '0;
                    r_m_clear    <= 1'b1;
                    r_state      <= S_CLEAR;
                end
                S_CLEAR: begin
                    r_m_clear <= 1'b0;
                    o_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_m_rw       <= '0;
                    r_m_clear    <= 1'b0;
                    o_gnt        <= '0;
                    o_resp_valid <= '0;
                    o_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_simple_axi_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_simple_axi_master_arbiter
// Description : Directed self-checking bench with a transaction-timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simple_axi_master_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 32;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     req_rw;
    logic [3*NREQ-1:0]     req_size;
    logic [32*NREQ-1:0]    req_addr;
    logic [WIDTH*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       resp_valid;
    logic [WIDTH-1:0]      resp_rdata;
    logic                  resp_error;
    logic                  resp_invalid;
    logic                  busy;

    simple_axi_master_arbiter_if #(.WIDTH(WIDTH)) bus ();

    simple_axi_master_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .i_clk          (clk),
        .i_rstn         (rstn),
        .i_req          (req),
        .i_req_rw       (req_rw),
        .i_req_size     (req_size),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .o_gnt          (gnt),
        .o_resp_valid   (resp_valid),
        .o_resp_rdata   (resp_rdata),
        .o_resp_error   (resp_error),
        .o_resp_invalid (resp_invalid),
        .o_busy         (busy),
        .m_bus          (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- master responder ----------------
    int               cfg_lat   = 2;
    logic [WIDTH-1:0] cfg_rdata = '0;
    logic             cfg_err   = 1'b0;
    logic             cfg_inv   = 1'b0;

    initial begin
        int   cnt;
        logic s_clr;
        logic [1:0] s_rw;
        cnt = 0;
        bus.m_rdata = '0; bus.m_wait = 1'b0; bus.m_done = 1'b0;
        bus.m_error = 1'b0; bus.m_invalid = 1'b0;
        forever begin
            @(negedge clk);
            s_clr = bus.m_clear;
            s_rw  = bus.m_rw;
            @(posedge clk);
            #1;
            if (!rstn) begin
                bus.m_wait = 1'b0; bus.m_done = 1'b0; bus.m_error = 1'b0;
                bus.m_invalid = 1'b0; bus.m_rdata = '0; cnt = 0;
            end else if (s_clr) begin
                bus.m_done = 1'b0;
                bus.m_wait = 1'b0;
            end else if (s_rw != 2'b00) begin
                bus.m_wait = 1'b1;
                cnt = cfg_lat;
            end else if (bus.m_wait) begin
                if (cnt > 1) cnt--;
                else begin
                    bus.m_wait    = 1'b0;
                    bus.m_done    = 1'b1;
                    bus.m_rdata   = cfg_rdata;
                    bus.m_error   = cfg_err;
                    bus.m_invalid = cfg_inv;
                end
            end
        end
    end

    // ---------------- transaction-timeline model ----------------
    // t counts clock edges since the grant edge; done_at is the edge where done was taken.
    bit               mdl_busy;
    int               mdl_w, mdl_ptr, mdl_t, mdl_done_at;
    logic [1:0]       mdl_rw;
    logic [2:0]       mdl_size;
    logic [31:0]      mdl_addr;
    logic [WIDTH-1:0] mdl_wdata, mdl_rdata;
    logic             mdl_err, mdl_inv;

    task automatic model_reset();
        mdl_busy = 0; mdl_w = 0; mdl_ptr = 0; mdl_t = 0; mdl_done_at = -1;
        mdl_rw = '0; mdl_size = '0; mdl_addr = '0; mdl_wdata = '0;
        mdl_rdata = '0; mdl_err = 1'b0; mdl_inv = 1'b0;
    endtask

    task automatic model_step();
        bit found;
        int j;
        found = 0;
        if (mdl_busy) begin
            mdl_t++;
            if (mdl_done_at < 0) begin
                if (mdl_t >= 2 && bus.m_done) begin
                    mdl_done_at = mdl_t;
                    mdl_rdata   = bus.m_rdata;
                    mdl_err     = bus.m_error;
                    mdl_inv     = bus.m_invalid;
                end
            end else if (mdl_t == mdl_done_at + 2) begin
                mdl_busy = 0;
            end
        end else if (req != '0 && !bus.m_wait && !bus.m_done) begin
            for (int k = 0; k < NREQ; k++) begin
                j = (mdl_ptr + k) % NREQ;
                if (!found && req[j]) begin
                    found = 1;
                    mdl_w = j;
                end
            end
            mdl_rw      = req_rw[mdl_w*2 +: 2];
            mdl_size    = req_size[mdl_w*3 +: 3];
            mdl_addr    = req_addr[mdl_w*32 +: 32];
            mdl_wdata   = req_wdata[mdl_w*WIDTH +: WIDTH];
            mdl_ptr     = (mdl_w + 1) % NREQ;
            mdl_busy    = 1;
            mdl_t       = 0;
            mdl_done_at = -1;
        end
    endtask

    task automatic compare_all();
        logic [NREQ-1:0] e_gnt, e_rv;
        logic [1:0]      e_rw;
        logic            e_clr;
        e_gnt = '0; e_rv = '0; e_rw = '0; e_clr = 1'b0;
        if (mdl_busy) begin
            if (mdl_done_at < 0 || mdl_t <= mdl_done_at) e_gnt = NREQ'(1) << mdl_w;
            if (mdl_t == 0) e_rw = mdl_rw;
            if (mdl_done_at >= 0 && mdl_t == mdl_done_at) e_rv = NREQ'(1) << mdl_w;
            if (mdl_done_at >= 0 && mdl_t == mdl_done_at + 1) e_clr = 1'b1;
        end
        check("mdl_gnt",        gnt,          e_gnt);
        check("mdl_m_rw",       bus.m_rw,     e_rw);
        check("mdl_resp_valid", resp_valid,   e_rv);
        check("mdl_m_clear",    bus.m_clear,  e_clr);
        check("mdl_busy",       busy,         mdl_busy);
        check("mdl_m_size",     bus.m_size,   mdl_size);
        check("mdl_m_addr",     bus.m_addr,   mdl_addr);
        check("mdl_m_wdata",    bus.m_wdata,  mdl_wdata);
        check("mdl_resp_rdata", resp_rdata,   mdl_rdata);
        check("mdl_resp_error", resp_error,   mdl_err);
        check("mdl_resp_inv",   resp_invalid, mdl_inv);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rstn) model_reset();
            else       model_step();
            @(negedge clk);
            if (!rstn) model_reset();
            compare_all();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int n, input logic [1:0] rw, input logic [2:0] size,
                           input logic [31:0] addr, input logic [WIDTH-1:0] wdata);
        req_rw[n*2 +: 2]            = rw;
        req_size[n*3 +: 3]          = size;
        req_addr[n*32 +: 32]        = addr;
        req_wdata[n*WIDTH +: WIDTH] = wdata;
        req[n]                      = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_gnt(input int maxc, output logic [NREQ-1:0] g);
        bit seen;
        seen = 0;
        g    = '0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clk);
            if (gnt != '0) begin g = gnt; seen = 1; end
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL gnt_timeout actual=none required=grant within %0d cycles", maxc);
        end
    endtask

    task automatic wait_resp(input int maxc, output logic [NREQ-1:0] v);
        bit seen;
        seen = 0;
        v    = '0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clk);
            if (resp_valid != '0) begin v = resp_valid; seen = 1; end
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL resp_timeout actual=none required=resp_valid within %0d cycles", maxc);
        end
    endtask

    function automatic int oh2idx(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic apply_reset();
        next_cycle();
        rstn = 1'b0;
        req  = '0;
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        logic [NREQ-1:0] g, v;
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        req = '0; req_rw = '0; req_size = '0; req_addr = '0; req_wdata = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", gnt, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_resp_valid", resp_valid, '0);
        check("rst_m_clear", bus.m_clear, 1'b0);
        next_cycle();
        rstn = 1'b1;

        // 1: single read from requester 0
        cfg_lat = 4; cfg_rdata = 32'hDEADBEEF;
        next_cycle();
        set_req(0, 2'b01, 3'd2, 32'h0000_1000, '0);
        wait_gnt(10, g);
        check("t1_gnt", g, 4'b0001);
        check("t1_m_rw", bus.m_rw, 2'b01);
        check("t1_m_addr", bus.m_addr, 32'h0000_1000);
        @(negedge clk);
        check("t1_m_rw_one_cycle", bus.m_rw, 2'b00);
        wait_resp(20, v);
        check("t1_resp_valid", v, 4'b0001);
        check("t1_rdata", resp_rdata, 32'hDEADBEEF);
        next_cycle();
        req[0] = 1'b0;
        @(negedge clk);
        check("t1_m_clear", bus.m_clear, 1'b1);
        check("t1_gnt_dropped", gnt, 4'b0000);

        // 2: all four held high from a fresh pointer
        apply_reset();
        cfg_lat = 2; cfg_rdata = 32'h0000_2222;
        for (int n = 0; n < NREQ; n++) set_req(n, 2'b10, 3'd2, 32'h2000 + n*4, 32'hA000 + n);
        for (int i = 0; i < 5; i++) begin
            wait_resp(30, v);
            check("t2_order", oh2idx(v), exp_order[i]);
        end
        next_cycle();
        req = '0;
        repeat (2) next_cycle();

        // 3: write from requester 2, request and fields withdrawn during WAIT
        cfg_lat = 3;
        set_req(2, 2'b10, 3'd2, 32'h0000_3000, 32'h55AA55AA);
        wait_gnt(10, g);
        check("t3_gnt", g, 4'b0100);
        check("t3_m_rw", bus.m_rw, 2'b10);
        next_cycle();
        req[2] = 1'b0;
        req_wdata[2*WIDTH +: WIDTH] = 32'h1234_5678;
        req_addr[2*32 +: 32]        = 32'hFFFF_0000;
        wait_resp(20, v);
        check("t3_resp_valid", v, 4'b0100);
        check("t3_wdata_held", bus.m_wdata, 32'h55AA55AA);
        check("t3_addr_held", bus.m_addr, 32'h0000_3000);
        repeat (2) next_cycle();

        // 4: slave error, then a normal read, then a forwarded rw=11 rejected by master
        cfg_err = 1'b1; cfg_rdata = 32'hBAD0_0001;
        set_req(1, 2'b01, 3'd2, 32'h0000_4000, '0);
        wait_resp(20, v);
        check("t4_resp_valid", v, 4'b0010);
        check("t4_error", resp_error, 1'b1);
        check("t4_invalid", resp_invalid, 1'b0);
        next_cycle();
        req[1] = 1'b0; cfg_err = 1'b0; cfg_rdata = 32'h0000_3333;
        next_cycle();
        set_req(3, 2'b01, 3'd1, 32'h0000_4100, '0);
        wait_gnt(10, g);
        check("t4_next_gnt", g, 4'b1000);
        wait_resp(20, v);
        check("t4_next_error", resp_error, 1'b0);
        check("t4_next_rdata", resp_rdata, 32'h0000_3333);
        next_cycle();
        req[3] = 1'b0; cfg_inv = 1'b1; cfg_rdata = 32'h0000_7777;
        next_cycle();
        set_req(0, 2'b11, 3'd2, 32'h0000_4200, 32'h0000_00FF);
        wait_gnt(10, g);
        check("t4_rw11_forward", bus.m_rw, 2'b11);
        wait_resp(20, v);
        check("t4_inv_flag", resp_invalid, 1'b1);
        check("t4_inv_error", resp_error, 1'b0);
        next_cycle();
        req[0] = 1'b0; cfg_inv = 1'b0;
        repeat (2) next_cycle();

        // 5: asynchronous reset during WAIT, then fresh arbitration
        cfg_lat = 8; cfg_rdata = 32'h0000_5555;
        set_req(1, 2'b01, 3'd2, 32'h0000_5000, '0);
        wait_gnt(10, g);
        next_cycle();
        next_cycle();
        rstn = 1'b0;
        req  = '0;
        #1;
        check("t5_rst_gnt", gnt, 4'b0000);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_m_addr", bus.m_addr, 32'h0);
        check("t5_rst_rdata", resp_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;
        cfg_lat = 2; cfg_rdata = 32'h0000_6666;
        set_req(3, 2'b01, 3'd2, 32'h0000_5300, '0);
        wait_gnt(10, g);
        check("t5_alone_gnt", g, 4'b1000);
        wait_resp(20, v);
        next_cycle();
        req[3] = 1'b0;
        next_cycle();
        set_req(0, 2'b01, 3'd2, 32'h0000_5000, '0);
        set_req(3, 2'b10, 3'd2, 32'h0000_5304, 32'h0000_0033);
        wait_gnt(10, g);
        check("t5_pair_first", g, 4'b0001);
        wait_resp(20, v);
        next_cycle();
        req[0] = 1'b0;
        wait_gnt(10, g);
        check("t5_pair_second", g, 4'b1000);
        wait_resp(20, v);
        next_cycle();
        req[3] = 1'b0;
        repeat (3) next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
